// File: rtl/timer_sequencer.sv
// Queues nonzero cycle counts and feeds them one at a time to a countdown timer.
// Optional replay of the queue is compiled in with `define SEQ_LOOP_EN (adds the loop port).
module timer_sequencer #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_cycles,
  output logic                       in_ready,
  input  logic                       start,
  input  logic                       abort,
  input  logic                       timer_busy,
`ifdef SEQ_LOOP_EN
  input  logic                       loop,
`endif
  output logic                       timer_load,
  output logic [WIDTH-1:0]           timer_cycles,
  output logic                       timer_clear,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       running,
  output logic                       done,
  output logic                       drop_zero
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_START, WAIT_DONE} state_t;

  state_t           state, next_state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic [LW-1:0]    count;
  logic             full, push, store, pop, recycle, write_en, finish;
  logic [WIDTH-1:0] head, write_data;

  // Replaying the head to the tail blocks new pushes for that cycle.
`ifdef SEQ_LOOP_EN
  assign recycle = loop && (state == ISSUE);
`else
  assign recycle = 1'b0;
`endif

  assign head        = mem[rd_ptr];
  assign full        = (count == LW'(DEPTH));
  assign in_ready    = !full && reset_n && !recycle;
  assign push        = in_valid && in_ready && !abort;
  assign store       = push && (in_cycles != '0);
  assign pop         = (state == ISSUE);
  assign write_en    = store || recycle;
  assign write_data  = recycle ? head : in_cycles;

  assign timer_load  = (state == ISSUE);
  assign timer_clear = !reset_n || abort;
  assign running     = (state != IDLE);
  assign level       = count;

  always_comb begin
    next_state = state;
    finish     = 1'b0;
    case (state)
      IDLE:       if (start && count != '0) next_state = ISSUE;
      ISSUE:      next_state = WAIT_START;
      WAIT_START: next_state = WAIT_DONE;
      WAIT_DONE: begin
        if (!timer_busy) begin
          if (count != '0 && start) begin
            next_state = ISSUE;
          end else begin
            next_state = IDLE;
            finish     = 1'b1;
          end
        end
      end
      default:    next_state = IDLE;
    endcase
    if (abort) begin
      next_state = IDLE;
      finish     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      timer_cycles <= '0;
      done         <= 1'b0;
      drop_zero    <= 1'b0;
    end else begin
      state     <= next_state;
      done      <= finish;
      drop_zero <= push && (in_cycles == '0);
      if (abort) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (write_en) wr_ptr <= wr_ptr + 1'b1;
        if (pop)      rd_ptr <= rd_ptr + 1'b1;
        if (write_en && !pop)      count <= count + 1'b1;
        else if (!write_en && pop) count <= count - 1'b1;
      end
      // The head is stable until ISSUE pops it, so it can be captured on entry.
      if (next_state == ISSUE) timer_cycles <= head;
    end
  end

  always_ff @(posedge clk) begin
    if (write_en && reset_n && !abort) mem[wr_ptr] <= write_data;
  end

endmodule

// File: tb/tb_timer_sequencer.sv
// Bench for timer_sequencer: emulated countdown timer, queue-based reference model,
// directed scenarios followed by random traffic.
module tb_timer_sequencer;

  localparam int DEPTH = 4;
  localparam int WIDTH = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             reset_n, in_valid, start, abort, timer_busy;
  logic [WIDTH-1:0] in_cycles;
  logic             in_ready, timer_load, timer_clear, running, done, drop_zero;
  logic [WIDTH-1:0] timer_cycles;
  logic [LW-1:0]    level;
  logic             loop_v;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  timer_sequencer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .in_valid(in_valid),
    .in_cycles(in_cycles),
    .in_ready(in_ready),
    .start(start),
    .abort(abort),
    .timer_busy(timer_busy),
`ifdef SEQ_LOOP_EN
    .loop(loop_v),
`endif
    .timer_load(timer_load),
    .timer_cycles(timer_cycles),
    .timer_clear(timer_clear),
    .level(level),
    .running(running),
    .done(done),
    .drop_zero(drop_zero)
  );

  // Emulated timer: busy rises the cycle after load and stays high for the loaded count.
  logic [WIDTH-1:0] tcnt;
  always @(posedge clk) begin
    if (timer_clear)      tcnt <= '0;
    else if (timer_load)  tcnt <= timer_cycles;
    else if (tcnt != '0)  tcnt <= tcnt - 1'b1;
  end
  assign timer_busy = (tcnt != '0);

  // Reference model: queue contents plus "what happens this cycle" flags.
  int m_q[$];
  bit m_load, m_guard, m_active, m_done, m_ambig, m_drop;
  int m_cycles;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit expReady();
    bit loop_now;
`ifdef SEQ_LOOP_EN
    loop_now = m_load && loop_v;
`else
    loop_now = 1'b0;
`endif
    return reset_n && (m_q.size() < DEPTH) && !loop_now;
  endfunction

  task automatic checkAll();
    checkOutput("level", 32'(level), 32'(m_q.size()));
    checkOutput("in_ready", 32'(in_ready), 32'(expReady()));
    checkOutput("timer_load", 32'(timer_load), 32'(m_load));
    if (m_load) checkOutput("timer_cycles", 32'(timer_cycles), 32'(m_cycles));
    if (!m_ambig) checkOutput("done", 32'(done), 32'(m_done));
    checkOutput("drop_zero", 32'(drop_zero), 32'(m_drop));
    checkOutput("running", 32'(running), 32'(m_load || m_guard || m_active));
    checkOutput("timer_clear", 32'(timer_clear), 32'(!reset_n || abort));
  endtask

  task automatic updateModel();
    bit accept, n_load, n_done, n_ambig, n_guard, n_active, loop_now;
    int head;
    if (!reset_n || abort) begin
      m_q.delete();
      {m_load, m_guard, m_active, m_done, m_ambig, m_drop} = '0;
      return;
    end
    accept = in_valid && expReady();
`ifdef SEQ_LOOP_EN
    loop_now = m_load && loop_v;
`else
    loop_now = 1'b0;
`endif
    n_load = 0; n_done = 0; n_ambig = 0; n_guard = 0; n_active = m_active;
    if (m_load) begin
      n_guard  = 1;
      n_active = 1;
    end else if (m_guard) begin
      n_guard = 0;
    end else if (m_active) begin
      if (!timer_busy) begin
        n_active = 0;
        if (m_q.size() > 0 && start) n_load = 1;
        else begin
          n_done  = 1;
          n_ambig = (m_q.size() > 0);
        end
      end
    end else if (start && m_q.size() > 0) begin
      n_load = 1;
    end
    if (n_load) m_cycles = m_q[0];
    if (m_load) begin
      head = m_q.pop_front();
      if (loop_now) m_q.push_back(head);
    end
    if (accept && in_cycles != '0) m_q.push_back(int'(in_cycles));
    m_drop   = accept && (in_cycles == '0);
    m_load   = n_load;
    m_guard  = n_guard;
    m_active = n_active;
    m_done   = n_done;
    m_ambig  = n_ambig;
  endtask

  task automatic applyStimulus(input bit v, input int c, input bit s, input bit a);
    in_valid  = v;
    in_cycles = WIDTH'(c);
    start     = s;
    abort     = a;
    @(negedge clk);
    checkAll();
    updateModel();
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycles(input int n, input bit s);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, s, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; in_cycles = '0; start = 1'b0; abort = 1'b0; loop_v = 1'b0;
    m_q.delete();
    {m_load, m_guard, m_active, m_done, m_ambig, m_drop} = '0;
    @(posedge clk); @(posedge clk); #1;
    $display("[TB] reset");
    applyStimulus(1'b0, 0, 1'b0, 1'b0);
    applyStimulus(1'b0, 0, 1'b0, 1'b0);
    reset_n = 1'b1;

    $display("[TB] ordered sequence 3,5,1");
    applyStimulus(1'b1, 3, 1'b0, 1'b0);
    applyStimulus(1'b1, 5, 1'b0, 1'b0);
    applyStimulus(1'b1, 1, 1'b0, 1'b0);
    idleCycles(30, 1'b1);
    start = 1'b0;

    $display("[TB] zero push");
    applyStimulus(1'b1, 0, 1'b0, 1'b0);
    idleCycles(3, 1'b1);

    $display("[TB] full queue");
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 2 + i, 1'b0, 1'b0);
    applyStimulus(1'b1, 7, 1'b0, 1'b0);
    checkOutput("full_level", 32'(level), 32'(DEPTH));
    applyStimulus(1'b0, 0, 1'b0, 1'b1);
    idleCycles(2, 1'b0);

    $display("[TB] abort while timing");
    applyStimulus(1'b1, 10, 1'b0, 1'b0);
    applyStimulus(1'b1, 2, 1'b0, 1'b0);
    applyStimulus(1'b1, 3, 1'b0, 1'b0);
    idleCycles(6, 1'b1);
    applyStimulus(1'b0, 0, 1'b1, 1'b1);
    idleCycles(4, 1'b1);
    idleCycles(2, 1'b0);

    $display("[TB] start dropped mid-sequence");
    applyStimulus(1'b1, 3, 1'b0, 1'b0);
    applyStimulus(1'b1, 4, 1'b0, 1'b0);
    idleCycles(3, 1'b1);
    idleCycles(12, 1'b0);
    checkOutput("held_level", 32'(level), 32'd1);
    idleCycles(15, 1'b1);

`ifdef SEQ_LOOP_EN
    $display("[TB] loop replay");
    applyStimulus(1'b0, 0, 1'b0, 1'b0);
    applyStimulus(1'b1, 2, 1'b0, 1'b0);
    applyStimulus(1'b1, 4, 1'b0, 1'b0);
    loop_v = 1'b1;
    idleCycles(30, 1'b1);
    loop_v = 1'b0;
    idleCycles(25, 1'b1);
`endif

    $display("[TB] random traffic");
    begin
      bit s = 1'b1;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 15) == 0) s = !s;
`ifdef SEQ_LOOP_EN
        if ($urandom_range(0, 19) == 0) loop_v = !loop_v;
`endif
        applyStimulus(1'($urandom_range(0, 1)), int'($urandom_range(0, 6)), s,
                      ($urandom_range(0, 49) == 0));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
